core_bus_arbiter: RTL and testbench

CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

---
 rtl/core_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_core_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// Two-master to one-slave bus arbiter: instruction fetch (0) and data cache (1) share one burst slave.
// Tie-break is fixed to the data cache unless CORE_BUS_ARB_RR_EN selects round-robin.
module core_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_req_i,
    input  logic [1:0]          m_we_i,
    input  logic [1:0][AW-1:0]  m_addr_i,
    input  logic [1:0][1:0]     m_len_i,
    input  logic [1:0][DW-1:0]  m_wdata_i,
    output logic [1:0]          m_ready_o,
    output logic [1:0]          m_data_ok_o,
    output logic [1:0]          m_busy_o,
    output logic [DW-1:0]       m_rdata_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [1:0]          s_len_o,
    output logic [DW-1:0]       s_wdata_o,
    input  logic                s_ready_i,
    input  logic                s_data_ok_i,
    input  logic [DW-1:0]       s_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ADDR = 3'b010,
        ST_DATA = 3'b100
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_gnt;
    logic        w_gnt_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;
    logic        w_tie_winner;
    logic [1:0]  w_gnt_mask;
    logic [1:0]  w_other_mask;

    assign w_gnt_mask   = {r_gnt, ~r_gnt};
    assign w_other_mask = {~r_gnt, r_gnt};

`ifdef CORE_BUS_ARB_RR_EN
    logic r_rr_ptr;
    logic w_rr_ptr_next;

    // Pointer moves to the other master only when a burst actually completes.
    assign w_rr_ptr_next = (r_state == ST_DATA && s_data_ok_i && r_cnt == 2'd0) ? ~r_gnt : r_rr_ptr;
    assign w_tie_winner  = r_rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
        end
    end
`else
    assign w_tie_winner = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_cnt_next   = r_cnt;
        m_ready_o    = 2'b00;
        m_data_ok_o  = 2'b00;
        m_busy_o     = 2'b00;
        m_rdata_o    = '0;
        s_req_o      = 1'b0;
        s_we_o       = 1'b0;
        s_addr_o     = '0;
        s_len_o      = 2'b00;
        s_wdata_o    = '0;

        case (r_state)
            ST_IDLE: begin
                if (|m_req_i) begin
                    w_gnt_next   = (m_req_i == 2'b11) ? w_tie_winner : m_req_i[1];
                    w_state_next = ST_ADDR;
                end
            end

            ST_ADDR: begin
                s_req_o   = m_req_i[r_gnt];
                s_we_o    = m_we_i[r_gnt];
                s_addr_o  = m_addr_i[r_gnt];
                s_len_o   = m_len_i[r_gnt];
                s_wdata_o = m_wdata_i[r_gnt];
                m_busy_o  = w_other_mask;
                // A withdrawn request abandons the address phase before the slave sees it.
                if (!m_req_i[r_gnt]) begin
                    w_state_next = ST_IDLE;
                end else if (s_ready_i) begin
                    m_ready_o    = w_gnt_mask;
                    w_cnt_next   = m_len_i[r_gnt];
                    w_state_next = ST_DATA;
                end
            end

            ST_DATA: begin
                s_we_o    = m_we_i[r_gnt];
                s_addr_o  = m_addr_i[r_gnt];
                s_len_o   = m_len_i[r_gnt];
                s_wdata_o = m_wdata_i[r_gnt];
                m_busy_o  = w_other_mask;
                m_rdata_o = s_rdata_i;
                if (s_data_ok_i) begin
                    m_data_ok_o = w_gnt_mask;
                    if (r_cnt == 2'd0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt - 2'd1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter with a beat scoreboard; honours CORE_BUS_ARB_RR_EN when defined.
module tb_core_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          m_req_i;
    logic [1:0]          m_we_i;
    logic [1:0][AW-1:0]  m_addr_i;
    logic [1:0][1:0]     m_len_i;
    logic [1:0][DW-1:0]  m_wdata_i;
    logic [1:0]          m_ready_o;
    logic [1:0]          m_data_ok_o;
    logic [1:0]          m_busy_o;
    logic [DW-1:0]       m_rdata_o;
    logic                s_req_o;
    logic                s_we_o;
    logic [AW-1:0]       s_addr_o;
    logic [1:0]          s_len_o;
    logic [DW-1:0]       s_wdata_o;
    logic                s_ready_i;
    logic                s_data_ok_i;
    logic [DW-1:0]       s_rdata_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] data;
    } beat_t;
    beat_t sb_q[$];

`ifdef CORE_BUS_ARB_RR_EN
    logic rr_ptr_model = 1'b0;
`endif

    core_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_i     (m_req_i),
        .m_we_i      (m_we_i),
        .m_addr_i    (m_addr_i),
        .m_len_i     (m_len_i),
        .m_wdata_i   (m_wdata_i),
        .m_ready_o   (m_ready_o),
        .m_data_ok_o (m_data_ok_o),
        .m_busy_o    (m_busy_o),
        .m_rdata_o   (m_rdata_o),
        .s_req_o     (s_req_o),
        .s_we_o      (s_we_o),
        .s_addr_o    (s_addr_o),
        .s_len_o     (s_len_o),
        .s_wdata_o   (s_wdata_o),
        .s_ready_i   (s_ready_i),
        .s_data_ok_i (s_data_ok_i),
        .s_rdata_i   (s_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tie_winner();
`ifdef CORE_BUS_ARB_RR_EN
        return int'(rr_ptr_model);
`else
        return 1;
`endif
    endfunction

    // Runs one full transaction starting from IDLE with requests already driven.
    task automatic do_txn(input int m, input int beats, input int rdy_dly,
                          input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        logic [1:0] mask;
        logic [1:0] other;
        beat_t      e;
        int         n;
        mask  = (m == 1) ? 2'b10 : 2'b01;
        other = ~mask;
        s_ready_i   = 1'b0;
        s_data_ok_i = 1'b0;
        n = 0;
        while (s_req_o !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("addr_phase_reached", s_req_o, 1);
        for (int d = 0; d < rdy_dly; d++) begin
            s_data_ok_i = 1'b1;
            #1;
            check("wait_addr_stable", s_addr_o, addr);
            check("wait_no_ready", m_ready_o, 0);
            check("wait_ignore_data_ok", m_data_ok_o, 0);
            step();
        end
        s_data_ok_i = 1'b0;
        s_ready_i   = 1'b1;
        #1;
        check("ready_grant", m_ready_o, mask);
        check("addr", s_addr_o, addr);
        check("we", s_we_o, we);
        check("busy_addr", m_busy_o, other);
        step();
        s_ready_i = 1'b0;
        #1;
        check("ready_single_pulse", m_ready_o, 0);
        for (int b = 0; b < beats; b++) begin
            e.mask = mask;
            e.data = $urandom;
            sb_q.push_back(e);
            s_data_ok_i = 1'b1;
            s_rdata_i   = e.data;
            #1;
            e = sb_q.pop_front();
            check("data_ok", m_data_ok_o, e.mask);
            check("rdata", m_rdata_o, e.data);
            check("busy_data", m_busy_o, other);
            if (we) check("wdata", s_wdata_o, wdata);
            step();
        end
        // Back in IDLE: a stray data_ok must not be forwarded.
        #1;
        check("idle_ignore_data_ok", m_data_ok_o, 0);
        check("idle_busy", m_busy_o, 0);
        s_data_ok_i = 1'b0;
`ifdef CORE_BUS_ARB_RR_EN
        rr_ptr_model = (m == 0);
`endif
        $display("txn master=%0d beats=%0d addr=0x%08h we=%0d", m, beats, addr, we);
    endtask

    initial begin
        int w;
        int n;
        rst         = 1'b1;
        m_req_i     = 2'b11;
        m_we_i      = 2'b00;
        m_addr_i[0] = 32'h0000_0100;
        m_addr_i[1] = 32'h0000_0200;
        m_len_i[0]  = 2'd3;
        m_len_i[1]  = 2'd3;
        m_wdata_i[0] = 32'h1111_1111;
        m_wdata_i[1] = 32'h2222_2222;
        s_ready_i   = 1'b1;
        s_data_ok_i = 1'b1;
        s_rdata_i   = 32'hcafe_f00d;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_req", s_req_o, 0);
        check("rst_s_we", s_we_o, 0);
        check("rst_s_addr", s_addr_o, 0);
        check("rst_s_len", s_len_o, 0);
        check("rst_s_wdata", s_wdata_o, 0);
        check("rst_m_ready", m_ready_o, 0);
        check("rst_m_data_ok", m_data_ok_o, 0);
        check("rst_m_busy", m_busy_o, 0);
        check("rst_m_rdata", m_rdata_o, 0);
        rst = 1'b0;

        // Simultaneous requests from reset, 4-beat burst.
        w = tie_winner();
        do_txn(w, 4, 0, m_addr_i[w], 1'b0, 32'h0);

        // Continuous contention with single-beat bursts.
        m_len_i[0] = 2'd0;
        m_len_i[1] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w = tie_winner();
            do_txn(w, 1, 0, m_addr_i[w], 1'b0, 32'h0);
        end

        // Master 0 alone after a history of master 1 wins.
        m_req_i = 2'b01;
        do_txn(0, 1, 0, m_addr_i[0], 1'b0, 32'h0);

        // Delayed slave ready with a 4-beat read.
        m_addr_i[0] = 32'h1c00_0000;
        m_len_i[0]  = 2'd3;
        do_txn(0, 4, 3, 32'h1c00_0000, 1'b0, 32'h0);

        // Single-beat write from the data cache.
        m_req_i      = 2'b10;
        m_we_i       = 2'b10;
        m_wdata_i[1] = 32'hdead_beef;
        do_txn(1, 1, 0, m_addr_i[1], 1'b1, 32'hdead_beef);
        m_req_i = 2'b00;
        m_we_i  = 2'b00;
        step();

        // Reset in the middle of a 4-beat burst.
        m_req_i    = 2'b01;
        m_len_i[0] = 2'd3;
        n = 0;
        while (s_req_o !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("rst_mid_addr_phase", s_req_o, 1);
        s_ready_i = 1'b1;
        step();
        s_ready_i   = 1'b0;
        m_req_i     = 2'b00;
        s_data_ok_i = 1'b1;
        step();
        step();
        check("rst_mid_third_beat", m_data_ok_o, 2'b01);
        rst = 1'b1;
        #1;
        check("rst_mid_data_ok", m_data_ok_o, 0);
        check("rst_mid_busy", m_busy_o, 0);
        check("rst_mid_s_addr", s_addr_o, 0);
        check("rst_mid_rdata", m_rdata_o, 0);
        step();
        rst = 1'b0;
        step();
        step();
        check("post_rst_data_ok", m_data_ok_o, 0);
        check("post_rst_busy", m_busy_o, 0);
        check("post_rst_s_req", s_req_o, 0);
        s_data_ok_i = 1'b0;
        $display("txn master=0 reset after 2 beats");

        // Master 0 withdraws during the address phase.
        m_req_i = 2'b01;
        n = 0;
        while (s_req_o !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("withdraw_addr_phase", s_req_o, 1);
        check("withdraw_busy", m_busy_o, 2'b10);
        m_req_i   = 2'b10;
        s_ready_i = 1'b1;
        #1;
        check("withdraw_no_ready", m_ready_o, 0);
        check("withdraw_no_s_req", s_req_o, 0);
        step();
        check("withdraw_idle_busy", m_busy_o, 0);
        check("withdraw_idle_ready", m_ready_o, 0);
        $display("txn master=0 withdrawn in address phase");
        do_txn(1, 1, 0, m_addr_i[1], 1'b0, 32'h0);
        m_req_i = 2'b00;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
